// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : State encoding and address-map constants for mem_access_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_RD   = 2'd1,
        IO_WAIT = 2'd2,
        RESP    = 2'd3
    } mac_state_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;
    // Byte address bits below WORD_LSB select a byte within a 32-bit word.
    localparam int          WORD_LSB        = 2;

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : Pipeline request/response, data_memory and MMIO signal bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if #(
    parameter int DM_AW = 16,
    parameter int IO_AW = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_fault;
    logic [DM_AW-1:0] dm_address;
    logic [31:0]      dm_data_in;
    logic             dm_write;
    logic             dm_read;
    logic [31:0]      dm_data_out;
    logic             dm_stall;
    logic             io_valid;
    logic             io_we;
    logic [IO_AW-1:0] io_addr;
    logic [31:0]      io_wdata;
    logic             io_ready;
    logic [31:0]      io_rdata;

    // Controller view.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  dm_data_out, dm_stall, io_ready, io_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output dm_address, dm_data_in, dm_write, dm_read,
        output io_valid, io_we, io_addr, io_wdata
    );

    // Pipeline plus memory/MMIO view.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output dm_data_out, dm_stall, io_ready, io_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  dm_address, dm_data_in, dm_write, dm_read,
        input  io_valid, io_we, io_addr, io_wdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl_addr_decode.sv
// ============================================================================
// Module   : mem_addr_decode
// Purpose  : Splits a byte address into BRAM/MMIO space and word addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_addr_decode
    import mem_pkg::*;
#(
    parameter int          DM_AW   = 16,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          IO_AW   = 8
) (
    input  logic [31:0]      addr_i,
    output logic             is_io_o,
    output logic             misaligned_o,
    output logic [DM_AW-1:0] dm_addr_o,
    output logic [IO_AW-1:0] io_addr_o
);

    logic [31:0] w_io_offset;
    logic        w_unused;

    assign is_io_o      = (addr_i >= IO_BASE);
    assign misaligned_o = |addr_i[WORD_LSB-1:0];
    // Upper DM bits are dropped on purpose: BRAM space aliases.
    assign dm_addr_o    = addr_i[WORD_LSB +: DM_AW];
    assign w_io_offset  = addr_i - IO_BASE;
    assign io_addr_o    = w_io_offset[WORD_LSB +: IO_AW];
    assign w_unused     = ^{w_io_offset[31:WORD_LSB+IO_AW], w_io_offset[WORD_LSB-1:0]};

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage controller steering loads/stores to BRAM or MMIO.
//            Optional MEM_ALIGN_CHECK_EN faults misaligned accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int          DM_AW   = 16,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter int          IO_AW   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);

    mac_state_t       state_q;
    logic             resp_valid_q;
    logic             fault_q;
    logic [31:0]      rdata_q;
    logic             io_valid_q;
    logic             io_we_q;
    logic [IO_AW-1:0] io_addr_q;
    logic [31:0]      io_wdata_q;

    logic             w_is_io;
    logic             w_misaligned;
    logic [DM_AW-1:0] w_dm_addr;
    logic [IO_AW-1:0] w_io_addr;
    logic             w_fault;
    logic             w_ready;
    logic             w_accept;
    logic             w_go_dm;
    logic [31:0]      w_rdata;
    logic             w_unused;

    mem_addr_decode #(
        .DM_AW   (DM_AW),
        .IO_BASE (IO_BASE),
        .IO_AW   (IO_AW)
    ) u_decode (
        .addr_i       (bus.req_addr),
        .is_io_o      (w_is_io),
        .misaligned_o (w_misaligned),
        .dm_addr_o    (w_dm_addr),
        .io_addr_o    (w_io_addr)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign w_fault         = w_misaligned;
    assign bus.resp_fault  = fault_q;
`else
    assign w_fault         = 1'b0;
    assign bus.resp_fault  = 1'b0;
`endif

    assign w_ready  = (state_q == IDLE);
    assign w_accept = bus.req_valid & w_ready;
    assign w_go_dm  = w_accept & ~w_is_io & ~w_fault;

    // BRAM strobes exist only in the accept cycle; the memory samples them at its edge.
    assign bus.dm_write   = w_go_dm & bus.req_we;
    assign bus.dm_read    = w_go_dm & ~bus.req_we;
    assign bus.dm_address = w_go_dm ? w_dm_addr : '0;
    assign bus.dm_data_in = (w_go_dm & bus.req_we) ? bus.req_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
            io_valid_q   <= 1'b0;
            io_we_q      <= 1'b0;
            io_addr_q    <= '0;
            io_wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        rdata_q <= '0;
                        fault_q <= w_fault;
                        if (w_fault) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else if (w_is_io) begin
                            state_q    <= IO_WAIT;
                            io_valid_q <= 1'b1;
                            io_we_q    <= bus.req_we;
                            io_addr_q  <= w_io_addr;
                            io_wdata_q <= bus.req_wdata;
                        end else if (bus.req_we) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q      <= DM_RD;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                DM_RD: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                IO_WAIT: begin
                    if (bus.io_ready) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        io_valid_q   <= 1'b0;
                        rdata_q      <= io_we_q ? 32'h0 : bus.io_rdata;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    fault_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Load data from BRAM is passed through in the cycle after dm_read.
    always_comb begin
        w_rdata = '0;
        if (state_q == DM_RD) begin
            w_rdata = bus.dm_data_out;
        end else if (state_q == RESP) begin
            w_rdata = rdata_q;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = w_rdata;
    assign bus.io_valid   = io_valid_q;
    assign bus.io_we      = io_we_q;
    assign bus.io_addr    = io_addr_q;
    assign bus.io_wdata   = io_wdata_q;

    assign w_unused = ^{bus.dm_stall, w_misaligned, fault_q};

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DM_AW(16), .IO_AW(8)) bus ();

    mem_access_ctrl #(
        .DM_AW   (16),
        .IO_BASE (32'hFFFF_0000),
        .IO_AW   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;

    // Behavioural BRAM: one-cycle read latency, stall in the read-issue cycle.
    logic [31:0] bram [logic [15:0]];
    assign bus.dm_stall = bus.dm_read;
    always @(posedge clk) begin
        if (bus.dm_write) bram[bus.dm_address] = bus.dm_data_in;
        if (bus.dm_read) bus.dm_data_out <= bram.exists(bus.dm_address) ? bram[bus.dm_address] : 32'h0;
    end

    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp: resp_valid=1 rdata=%h fault=%b, required no response",
                         bus.resp_rdata, bus.resp_fault);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.resp_rdata, bus.resp_fault} !== {mon_e.rdata, mon_e.fault}) begin
                    failures++;
                    $display("FAIL resp_data: rdata=%h fault=%b, required rdata=%h fault=%b",
                             bus.resp_rdata, bus.resp_fault, mon_e.rdata, mon_e.fault);
                end
            end
        end
    end

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault);
        int n;
        @(posedge clk); #1;
        drive_req(we, addr, wdata);
        exp_q.push_back({exp_rdata, exp_fault});
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_accept: req_ready=%b, required 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_resp: ready=%b valid=%b rdata=%h fault=%b, required 1 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault);
        end
        checks++;
        if ({bus.dm_read, bus.dm_write, bus.io_valid, bus.dm_address, bus.io_addr, bus.io_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_bus: dm_rd=%b dm_wr=%b io_valid=%b dm_addr=%h io_addr=%h io_wdata=%h, required all 0",
                     bus.dm_read, bus.dm_write, bus.io_valid, bus.dm_address, bus.io_addr, bus.io_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_dm_store();
        @(posedge clk); #1;
        drive_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        exp_q.push_back({32'h0, 1'b0});
        @(negedge clk);
        checks++;
        if ({bus.dm_write, bus.dm_read, bus.dm_address, bus.dm_data_in} !== {1'b1, 1'b0, 16'h0040, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL dm_store_issue: wr=%b rd=%b addr=%h data=%h, required 1 0 0040 deadbeef",
                     bus.dm_write, bus.dm_read, bus.dm_address, bus.dm_data_in);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.dm_write, bus.req_ready} !== 3'b100) begin
            failures++;
            $display("FAIL dm_store_resp: valid=%b wr=%b ready=%b, required 1 0 0",
                     bus.resp_valid, bus.dm_write, bus.req_ready);
        end
    endtask

    task automatic test_dm_load();
        @(posedge clk); #1;
        drive_req(1'b0, 32'h0000_0100, 32'h0);
        exp_q.push_back({32'hDEAD_BEEF, 1'b0});
        @(negedge clk);
        checks++;
        if ({bus.dm_read, bus.dm_write, bus.dm_address} !== {1'b1, 1'b0, 16'h0040}) begin
            failures++;
            $display("FAIL dm_load_issue: rd=%b wr=%b addr=%h, required 1 0 0040",
                     bus.dm_read, bus.dm_write, bus.dm_address);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.resp_valid, bus.req_ready, bus.dm_read} !== 3'b100) begin
            failures++;
            $display("FAIL dm_load_resp: valid=%b ready=%b rd=%b, required 1 0 0",
                     bus.resp_valid, bus.req_ready, bus.dm_read);
        end
    endtask

    task automatic test_io_ready_ignored();
        @(posedge clk); #1;
        bus.io_ready = 1'b1;
        bus.io_rdata = 32'h0000_0BAD;
        @(posedge clk); #1;
        bus.io_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.io_valid, bus.resp_valid} !== 3'b100) begin
            failures++;
            $display("FAIL io_ready_idle: ready=%b io_valid=%b resp_valid=%b, required 1 0 0",
                     bus.req_ready, bus.io_valid, bus.resp_valid);
        end
    endtask

    task automatic test_mmio(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int waits, input logic [7:0] exp_io_addr);
        @(posedge clk); #1;
        drive_req(we, addr, wdata);
        exp_q.push_back({(we ? 32'h0 : rdata), 1'b0});
        @(negedge clk);
        checks++;
        if ({bus.dm_read, bus.dm_write, bus.io_valid} !== 3'b000) begin
            failures++;
            $display("FAIL mmio_accept: dm_rd=%b dm_wr=%b io_valid=%b, required 0 0 0",
                     bus.dm_read, bus.dm_write, bus.io_valid);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= waits; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.io_valid, bus.io_we, bus.io_addr, bus.io_wdata, bus.dm_read, bus.dm_write, bus.resp_valid}
                    !== {1'b1, we, exp_io_addr, wdata, 3'b000}) begin
                failures++;
                $display("FAIL mmio_wait%0d: io_valid=%b we=%b addr=%h wdata=%h dm=%b%b resp=%b, required 1 %b %h %h 00 0",
                         i, bus.io_valid, bus.io_we, bus.io_addr, bus.io_wdata, bus.dm_read, bus.dm_write,
                         bus.resp_valid, we, exp_io_addr, wdata);
            end
            if (i == waits) begin
                bus.io_ready = 1'b1;
                bus.io_rdata = rdata;
            end
            @(posedge clk); #1;
            bus.io_ready = 1'b0;
            bus.io_rdata = 32'h0;
        end
        @(negedge clk);
        checks++;
        if ({bus.io_valid, bus.resp_valid} !== 2'b01) begin
            failures++;
            $display("FAIL mmio_resp: io_valid=%b resp_valid=%b, required 0 1", bus.io_valid, bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send(1'b1, 32'h200 + 32'(4 * i), 32'hA500_0000 + 32'(i), 32'h0, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'hA500_0000 + 32'(i), 1'b0});
            @(negedge clk);
            checks++;
            if ({bus.req_ready, bus.dm_read, bus.dm_address} !== {1'b1, 1'b1, 16'(16'h80 + i)}) begin
                failures++;
                $display("FAIL b2b_accept%0d: ready=%b rd=%b addr=%h, required 1 1 %h",
                         i, bus.req_ready, bus.dm_read, bus.dm_address, 16'(16'h80 + i));
            end
            @(posedge clk); #1;
            if (i < 3) bus.req_addr = 32'h200 + 32'(4 * (i + 1));
            else       bus.req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.req_ready, bus.dm_read, bus.resp_valid} !== 3'b001) begin
                failures++;
                $display("FAIL b2b_wait%0d: ready=%b rd=%b resp_valid=%b, required 0 0 1",
                         i, bus.req_ready, bus.dm_read, bus.resp_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alias();
        send(1'b1, 32'h0004_0100, 32'h1357_2468, 32'h0, 1'b0);
        send(1'b0, 32'h0000_0100, 32'h0, 32'h1357_2468, 1'b0);
    endtask

    task automatic test_misaligned();
        @(posedge clk); #1;
        drive_req(1'b0, 32'h0000_0102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        exp_q.push_back({32'h0, 1'b1});
        @(negedge clk);
        checks++;
        if ({bus.dm_read, bus.dm_write} !== 2'b00) begin
            failures++;
            $display("FAIL misaligned_issue: rd=%b wr=%b, required 0 0", bus.dm_read, bus.dm_write);
        end
`else
        exp_q.push_back({32'h1357_2468, 1'b0});
        @(negedge clk);
        checks++;
        if ({bus.dm_read, bus.dm_address} !== {1'b1, 16'h0040}) begin
            failures++;
            $display("FAIL misaligned_issue: rd=%b addr=%h, required 1 0040", bus.dm_read, bus.dm_address);
        end
`endif
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_resp: resp_valid=%b, required 1", bus.resp_valid);
        end
    endtask

    task automatic test_reset_io_wait();
        @(posedge clk); #1;
        drive_req(1'b0, 32'hFFFF_0004, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.io_valid, bus.req_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rst_io_pre: io_valid=%b ready=%b, required 1 0", bus.io_valid, bus.req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.io_valid, bus.req_ready, bus.resp_valid} !== 3'b010) begin
            failures++;
            $display("FAIL rst_io_during: io_valid=%b ready=%b resp_valid=%b, required 0 1 0",
                     bus.io_valid, bus.req_ready, bus.resp_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.io_ready = 1'b1;
        bus.io_rdata = 32'h0000_0BAD;
        @(posedge clk); #1;
        bus.io_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.io_valid, bus.resp_valid} !== 3'b100) begin
            failures++;
            $display("FAIL rst_io_after: ready=%b io_valid=%b resp_valid=%b, required 1 0 0",
                     bus.req_ready, bus.io_valid, bus.resp_valid);
        end
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.io_ready  = 1'b0;
        bus.io_rdata  = 32'h0;

        test_reset();
        test_dm_store();
        test_dm_load();
        test_io_ready_ignored();
        test_mmio(1'b0, 32'hFFFF_0008, 32'h0, 32'h0000_005A, 3, 8'h02);
        test_mmio(1'b1, 32'hFFFF_0010, 32'hCAFE_1234, 32'h0000_0077, 1, 8'h04);
        test_back_to_back();
        test_alias();
        test_misaligned();
        test_reset_io_wait();

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: outstanding=%0d, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
